// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC, fetch/exec sequencing, branch resolution and carry flag
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  brOp,
    input  logic [21:0] label,
    input  logic [31:0] rsData,
    input  logic        aluCarry,
    input  logic        flagWe,
    input  logic        halt,
    input  logic        hold,
    output logic [31:0] instrAddr,
    output logic        fetchEn,
    output logic        commit,
    output logic [31:0] linkAddr,
    output logic        carryFlag,
    output logic        halted,
    output logic        misalign
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetchStateT;

    localparam logic [3:0] OP_B    = 4'd1;
    localparam logic [3:0] OP_BR   = 4'd2;
    localparam logic [3:0] OP_BLTZ = 4'd3;
    localparam logic [3:0] OP_BZ   = 4'd4;
    localparam logic [3:0] OP_BNZ  = 4'd5;
    localparam logic [3:0] OP_BL   = 4'd6;
    localparam logic [3:0] OP_BCY  = 4'd7;
    localparam logic [3:0] OP_BNCY = 4'd8;

    fetchStateT  state;
    fetchStateT  stateNext;
    logic [31:0] pcPlus4;
    logic [31:0] relTarget;
    logic [31:0] rawTarget;
    logic [31:0] target;
    logic [31:0] pcNext;
    logic        taken;
    logic        trap;

    assign pcPlus4   = instrAddr + 32'd4;
    assign linkAddr  = pcPlus4;
    assign relTarget = pcPlus4 + {{8{label[21]}}, label, 2'b00};
    assign rawTarget = (brOp == OP_BR) ? rsData : relTarget;

    // Conditional kinds see the carry registered before this commit.
    always_comb begin
        taken = 1'b0;
        case (brOp)
            OP_B, OP_BR, OP_BL: taken = 1'b1;
            OP_BLTZ:            taken = rsData[31];
            OP_BZ:              taken = (rsData == 32'd0);
            OP_BNZ:             taken = (rsData != 32'd0);
            OP_BCY:             taken = carryFlag;
            OP_BNCY:            taken = ~carryFlag;
            default:            taken = 1'b0;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign trap   = taken & (rawTarget[1:0] != 2'b00);
    assign target = rawTarget;
`else
    assign trap   = 1'b0;
    assign target = rawTarget & ~32'd3;
`endif

    always_comb begin
        stateNext = state;
        fetchEn   = 1'b0;
        commit    = 1'b0;
        halted    = 1'b0;
        pcNext    = instrAddr;
        case (state)
            FETCH: begin
                fetchEn   = 1'b1;
                stateNext = EXEC;
            end
            EXEC: begin
                if (!hold) begin
                    commit = 1'b1;
                    // Halt and trapped branches leave the PC on the faulting instruction.
                    if (halt || trap) begin
                        stateNext = HALT;
                    end else begin
                        stateNext = FETCH;
                        pcNext    = taken ? target : pcPlus4;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            instrAddr <= RESET_PC;
            carryFlag <= 1'b0;
        end else begin
            state     <= stateNext;
            instrAddr <= pcNext;
            if (commit && flagWe) begin
                carryFlag <= aluCarry;
            end
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic misalignReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalignReg <= 1'b0;
        end else if (commit && trap) begin
            misalignReg <= 1'b1;
        end
    end

    assign misalign = misalignReg;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  brOp = 4'd0;
    logic [21:0] label = 22'd0;
    logic [31:0] rsData = 32'd0;
    logic        aluCarry = 1'b0;
    logic        flagWe = 1'b0;
    logic        halt = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] instrAddr;
    logic        fetchEn;
    logic        commit;
    logic [31:0] linkAddr;
    logic        carryFlag;
    logic        halted;
    logic        misalign;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst       (rst),
        .brOp      (brOp),
        .label     (label),
        .rsData    (rsData),
        .aluCarry  (aluCarry),
        .flagWe    (flagWe),
        .halt      (halt),
        .hold      (hold),
        .instrAddr (instrAddr),
        .fetchEn   (fetchEn),
        .commit    (commit),
        .linkAddr  (linkAddr),
        .carryFlag (carryFlag),
        .halted    (halted),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        carry;
    } sbEntry;

    sbEntry      sbQ[$];
    sbEntry      monE;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mPc = RESET_PC;
    logic        mCarry = 1'b0;
    logic        mTrap = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT in FETCH; returns just after the commit edge.
    task automatic runInstr(input logic [3:0] op, input logic [21:0] lbl, input logic [31:0] rs,
                            input logic cyIn, input logic fwe, input logic hlt, input int holdCycles);
        logic               tk;
        logic signed [31:0] off;
        logic [31:0]        tgt;
        sbEntry             e;
        @(negedge clk);
        hold = (holdCycles > 0);
        #1;
        check("fetch_en", fetchEn, 1'b1);
        check("fetch_nocommit", commit, 1'b0);
        @(negedge clk);
        brOp = op; label = lbl; rsData = rs; aluCarry = cyIn; flagWe = fwe; halt = hlt;
        #1;
        check("exec_pc", instrAddr, mPc);
        check("link_addr", linkAddr, mPc + 32'd4);
        check("exec_fetchen", fetchEn, 1'b0);
        for (int i = 0; i < holdCycles; i++) begin
            check("hold_commit", commit, 1'b0);
            @(negedge clk);
            check("hold_pc", instrAddr, mPc);
        end
        hold = 1'b0;
        case (op)
            4'd1, 4'd2, 4'd6: tk = 1'b1;
            4'd3:             tk = rs[31];
            4'd4:             tk = (rs == 32'd0);
            4'd5:             tk = (rs != 32'd0);
            4'd7:             tk = mCarry;
            4'd8:             tk = !mCarry;
            default:          tk = 1'b0;
        endcase
        off = $signed(lbl);
        off = off <<< 2;
        tgt = (op == 4'd2) ? rs : (mPc + 32'd4 + off);
`ifdef PC_MISALIGN_TRAP_EN
        mTrap = tk && (tgt[1:0] != 2'b00);
`else
        mTrap = 1'b0;
        tgt = {tgt[31:2], 2'b00};
`endif
        e.pc    = (hlt || mTrap) ? mPc : (tk ? tgt : mPc + 32'd4);
        e.carry = fwe ? cyIn : mCarry;
        sbQ.push_back(e);
        #1;
        check("exec_commit", commit, 1'b1);
        @(posedge clk);
        #1;
        mPc = e.pc;
        mCarry = e.carry;
        brOp = 4'd0; label = 22'd0; rsData = 32'd0; aluCarry = 1'b0; flagWe = 1'b0; halt = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (commit === 1'b1) begin
                @(posedge clk);
                #1;
                if (sbQ.size() == 0) begin
                    check("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    monE = sbQ.pop_front();
                    check("sb_pc", instrAddr, monE.pc);
                    check("sb_carry", {31'd0, carryFlag}, {31'd0, monE.carry});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pc", instrAddr, RESET_PC);
        check("rst_fetchen", fetchEn, 1'b1);
        check("rst_commit", commit, 1'b0);
        check("rst_carry", carryFlag, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 4; i++) runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_seq", instrAddr, 32'h10);
        runInstr(4'd1, 22'h3FFFFC, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_b_neg", instrAddr, 32'h04);
        for (int i = 0; i < 3; i++) runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        runInstr(4'd4, 22'h3FFFFC, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_bz_taken", instrAddr, 32'h04);
        for (int i = 0; i < 3; i++) runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        runInstr(4'd4, 22'h3FFFFC, 32'd5, 1'b0, 1'b0, 1'b0, 0);
        check("tp_bz_not", instrAddr, 32'h14);
        runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        runInstr(4'd0, 22'd0, 32'd0, 1'b1, 1'b1, 1'b0, 0);
        check("tp_carry_set", carryFlag, 1'b1);
        runInstr(4'd7, 22'd2, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_bcy_taken", instrAddr, 32'h2C);
        runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b1, 1'b0, 0);
        runInstr(4'd7, 22'd2, 32'd0, 1'b1, 1'b1, 1'b0, 0);
        check("tp_bcy_same_cycle", instrAddr, 32'h34);
        runInstr(4'd8, 22'h3FFFFF, 32'd0, 1'b0, 1'b0, 1'b0, 3);
        check("tp_hold_adv", instrAddr, 32'h38);
        runInstr(4'd3, 22'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0);
        check("tp_bltz", instrAddr, 32'h40);

        runInstr(4'd1, 22'd5, 32'd0, 1'b0, 1'b0, 1'b1, 0);
        check("halt_rise", halted, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_pc", instrAddr, 32'h40);
            check("halt_commit", commit, 1'b0);
            check("halt_fetchen", fetchEn, 1'b0);
        end
        rst = 1'b0;
        #1;
        check("halt_rst_pc", instrAddr, RESET_PC);
        check("halt_rst_halted", halted, 1'b0);
        check("halt_rst_carry", carryFlag, 1'b0);
        mPc = RESET_PC;
        mCarry = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        runInstr(4'd6, 22'd3, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_bl", instrAddr, 32'h10);
        runInstr(4'd5, 22'h3FFFFE, 32'd1, 1'b0, 1'b0, 1'b0, 1);
        check("tp_bnz", instrAddr, 32'h0C);
        runInstr(4'd9, 22'd5, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_op9_none", instrAddr, 32'h10);
        runInstr(4'd8, 22'd1, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_bncy", instrAddr, 32'h18);
        runInstr(4'd2, 22'd0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 0);
        runInstr(4'd0, 22'd0, 32'd0, 1'b0, 1'b0, 1'b0, 0);
        check("tp_wrap", instrAddr, 32'h0);

        runInstr(4'd0, 22'd0, 32'd0, 1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        brOp = 4'd1; label = 22'd5; flagWe = 1'b1; aluCarry = 1'b0; hold = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midhold_pc", instrAddr, RESET_PC);
        check("midhold_commit", commit, 1'b0);
        check("midhold_carry", carryFlag, 1'b0);
        check("midhold_fetchen", fetchEn, 1'b1);
        brOp = 4'd0; label = 22'd0; flagWe = 1'b0; hold = 1'b0;
        mPc = RESET_PC;
        mCarry = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        runInstr(4'd2, 22'd0, 32'h0000_0102, 1'b0, 1'b0, 1'b0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        check("misal_pc", instrAddr, RESET_PC);
        check("misal_halted", halted, 1'b1);
        check("misal_flag", misalign, 1'b1);
`else
        check("misal_pc", instrAddr, 32'h100);
        check("misal_halted", halted, 1'b0);
        check("misal_flag", misalign, 1'b0);
`endif
        repeat (2) @(negedge clk);
        check("sb_drained", sbQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Program-counter and fetch-sequencing stage of the KGP-RISC core; sits directly upstream of the datapath.
- Holds the PC, drives the instruction-memory address, and sequences each instruction through a two-state fetch/execute loop so the synchronous instruction BRAM has a full cycle to return data.
- Resolves every branch kind (unconditional, register, conditional on register value, carry-flag) and produces the link address.
- Owns the architectural carry flag.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.

**Ports**
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `brOp`  in  4  branch kind from decoder: 0 none, 1 b, 2 br, 3 bltz, 4 bz, 5 bnz, 6 bl, 7 bcy, 8 bncy; 9–15 treated as none.
- `label`  in  22  signed word offset from the instruction.
- `rsData`  in  32  register-file read port 1 value.
- `aluCarry`  in  1  ALU carry-out for the current instruction.
- `flagWe`  in  1  current instruction updates the carry flag.
- `halt`  in  1  current instruction is halt.
- `hold`  in  1  stretches EXEC, e.g. for a data-memory wait.
- `instrAddr`  out  32  registered PC; drives instruction memory.
- `fetchEn`  out  1  high in FETCH; BRAM read enable.
- `commit`  out  1  high for one cycle when the instruction retires; the datapath gates `regWrite`/`memWrite` with it.
- `linkAddr`  out  32  `instrAddr + 4`, combinational.
- `carryFlag`  out  1  latched carry flag.
- `halted`  out  1  high in HALT.
- `misalign`  out  1  sticky misaligned-target indicator; tied 0 unless `PC_MISALIGN_TRAP_EN` is defined.

## Operation

**States**
- FETCH → EXEC: unconditional, one cycle.
- EXEC with `hold`=1: stays in EXEC.
- EXEC with `hold`=0: commits, then goes to FETCH, or to HALT if `halt`=1.
- HALT: left only by reset.

**Commit and branch resolution**
- `commit` = (state == EXEC) & ~`hold`.
- Relative target = `instrAddr` + 4 + (sign-extended `label` << 2), computed mod 2^32.
- Taken conditions, by `brOp`:
  - b, bl: always.
  - br: always; target = `rsData`.
  - bltz: `rsData[31]`.
  - bz: `rsData == 0`.
  - bnz: `rsData != 0`.
  - bcy: `carryFlag`.
  - bncy: `~carryFlag`.
- bl only redirects the PC; the datapath writes `linkAddr` to r31.
- On commit, PC ← taken ? target : `instrAddr` + 4.

**Halt and carry**
- Halt takes priority over branching. On a halt commit the PC is not updated, so `instrAddr` keeps pointing at the halt instruction.
- On commit with `flagWe`=1: `carryFlag` ← `aluCarry`.
- bcy/bncy read the carry value registered before the current commit, never the same-cycle `aluCarry`.

**Boundaries**
- `hold` asserted in FETCH is ignored.
- PC wraps from `32'hFFFF_FFFC` to 0.
- Reset may arrive in any state, including mid-hold: it aborts the instruction with no commit.

## Timing

- Reset values: `instrAddr` = `RESET_PC`, state FETCH, `fetchEn` = 1, `commit` = 0, `carryFlag` = 0, `halted` = 0, `misalign` = 0.
- Steady state is 2 cycles per instruction; each asserted `hold` cycle adds 1.
- `instr` is valid from the BRAM throughout EXEC.
- `instrAddr` and `carryFlag` change only on the rising edge that ends a commit cycle.
- `halted` rises on the edge after the halt commit.
- `linkAddr` is combinational from the PC register.
- Registers: PC, carry flag, misalign bit, state (2 bits).

## Configuration

Macro: `PC_MISALIGN_TRAP_EN`.

**Defined**
- A taken branch whose target has bits [1:0] ≠ 00 (only possible for br) does not update the PC.
- Instead, the FSM enters HALT and sets `misalign` to 1, which holds until reset.
- A halt commit from a misaligned br still leaves `instrAddr` unchanged.

**Undefined**
- The target's bits [1:0] are forced to 00.
- The `misalign` output is tied 0.

## Test plan

- **Reset and sequential fetch:** `rst` low then high, `RESET_PC`=0, `brOp`=0 → `instrAddr` sequence 0, 4, 8 on every second edge; `commit` pulses once per 2 cycles.
- **Relative branches:** at PC 0x10, b with `label`=-4 → next PC 0x04. At PC 0x10, bz with `rsData`=0 → 0x04. At PC 0x10, bz with `rsData`=5 → 0x14.
- **Carry ordering:** commit `flagWe`=1, `aluCarry`=1, then bcy with `label`=2 at PC 0x20 → PC 0x2C. A bcy committing in the same cycle as `flagWe`=1, `aluCarry`=1, with prior carry 0 → not taken.
- **Hold:** `hold` high for 3 EXEC cycles → no `commit`, PC frozen; release → single `commit`, PC advances by 4.
- **Halt:** halt at PC 0x40 → `halted`=1, `instrAddr` stays 0x40 for 10 cycles; `rst` low → PC = `RESET_PC`, `halted`=0.
- **Misaligned br:** br with `rsData`=0x102 → with `PC_MISALIGN_TRAP_EN`: `halted`=1, `misalign`=1, PC unchanged. Without it: PC = 0x100.
